config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Drives the configuration bus that every tile in the array receives. This is the writer side of the tiles' config_addr/config_data inputs.
- Accepts a byte stream from an external host or boot ROM with a valid/ready handshake.
- Assembles each 8-byte record into an address/data pair, then broadcasts it on config_addr/config_data for a programmable number of cycles.
- Tile select is config_addr[31:16] == tile_id; config_addr[15:0] is the register index inside the tile.

Parameters:
- HOLD_CYCLES, 2, cycles each address/data pair is held on the bus (must be >= 1).
- IDLE_ADDR, 32'hFFFF_FFFF, address driven whenever no write is active; tile_id 16'hFFFF is reserved so that no tile matches it.
- END_ADDR, 32'hFFFF_FFFE, record address that terminates a load; it is never broadcast.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  single-cycle pulse; begins a load when in IDLE or DONE
- in_data  input  8  bitstream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- config_addr  output  32  broadcast config address
- config_data  output  32  broadcast config data
- busy  output  1  load in progress
- done  output  1  last load terminated by END_ADDR; sticky until next start
- records_written  output  16  count of records broadcast in the current load; saturates at 16'hFFFF
- error  output  1  optional feature only (tied 0 when the feature is compiled out)

Behaviour:
- Reset values (asynchronous, all outputs): config_addr = IDLE_ADDR, config_data = 0, in_ready = 0, busy = 0, done = 0, records_written = 0, error = 0, state = IDLE.
- Record format: 8 bytes, little-endian. Bytes 0-3 are the address, bytes 4-7 are the data.
- Byte transfer happens only when in_valid && in_ready on a rising edge.
- All outputs are registered.
- States:
  - IDLE: in_ready = 0.
    - start -> RECV; clear byte counter, records_written, done and error; busy = 1.
  - RECV: in_ready = 1.
    - Shift each accepted byte into a 64-bit assembly register.
    - When the 8th byte is accepted: if the address equals END_ADDR -> DONE; otherwise -> DRIVE.
    - in_valid low simply stalls, with no timeout.
  - DRIVE: in_ready = 0.
    - config_addr/config_data show the record starting the cycle after the 8th byte is accepted and stay stable for exactly HOLD_CYCLES cycles.
    - On leaving DRIVE: config_addr returns to IDLE_ADDR, config_data returns to 0, records_written increments (saturating at 16'hFFFF).
    - Next state is RECV, so at least one idle-address cycle separates consecutive records.
  - DONE: busy = 0, done = 1, in_ready = 0, config_addr = IDLE_ADDR.
    - start -> RECV, as from IDLE.
- Minimum throughput: 8 + HOLD_CYCLES cycles per record.
- start while busy (RECV/DRIVE) is ignored.
- A record whose address equals IDLE_ADDR is broadcast like any other; it harmlessly matches no tile.
- A record with address END_ADDR never appears on config_addr.
- rst asserted mid-load: immediate asynchronous return to reset values; partial record discarded; bus goes to IDLE_ADDR without a glitch to other addresses.
- A byte offered in the same cycle the FSM leaves RECV for DRIVE is not accepted (in_ready is registered low in DRIVE).

Optional Feature:
- Macro: CONFIG_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Each record is 9 bytes; byte 8 is the XOR of bytes 0-7.
  - Mismatch: the record is not broadcast, error is set sticky until the next start, and the FSM goes to DONE with done = 0.
  - A matching END_ADDR record -> DONE with done = 1.
- Without the macro: 8-byte records and error is constant 0.

Test Plan:
- Reset mid-DRIVE (rst pulse while config_addr = 32'h0003_0001) -> all outputs asynchronously at reset values; next start plus a valid record loads correctly.
- start, then record addr 32'h0005_0002 / data 32'hDEAD_BEEF, then END record, HOLD_CYCLES = 2 -> config_addr = 32'h0005_0002 and config_data = 32'hDEAD_BEEF for exactly 2 cycles, IDLE_ADDR otherwise; done = 1, records_written = 1, busy = 0.
- Three back-to-back records with in_valid held high, then END -> each pair appears in order, at least 1 IDLE_ADDR cycle between them, records_written = 3; in_ready low during every DRIVE.
- in_valid toggled 0/1 every other cycle during RECV -> the same bus output as the continuous case, only delayed; no byte dropped or duplicated.
- start pulsed during DRIVE -> ignored; records_written not cleared; load completes normally.
- With CONFIG_LOADER_CHECKSUM_EN: record with a corrupted checksum byte (0x00 instead of 0x5A) -> no broadcast, error = 1, done = 0, in_ready = 0; the next start clears error.

Source files
------------

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// config_loader: assembles 8-byte host records into config_addr/config_data
// writes and broadcasts each one for HOLD_CYCLES cycles.
// Optional macro CONFIG_LOADER_CHECKSUM_EN appends an XOR checksum byte.
// Revision: 1.0
// ============================================================================
module config_loader #(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] END_ADDR    = 32'hFFFF_FFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] records_written,
    output logic        error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd8;
`else
    localparam logic [3:0] LAST_BYTE = 4'd7;
`endif

    state_t        state;
    logic [3:0]    byte_cnt;
    logic [63:0]   shreg;
    logic [HW-1:0] hold_cnt;
    logic [63:0]   rec_next;
    logic          csum_bad;

    // Bytes arrive LSB first; once 8 are held, a checksum byte leaves shreg intact.
    assign rec_next = (byte_cnt < 4'd8) ? {in_data, shreg[63:8]} : shreg;

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign csum_bad = (in_data != csum);
`else
    assign csum_bad = 1'b0;
    assign error    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            byte_cnt        <= 4'd0;
            shreg           <= 64'd0;
            hold_cnt        <= '0;
            in_ready        <= 1'b0;
            config_addr     <= IDLE_ADDR;
            config_data     <= 32'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            records_written <= 16'd0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum            <= 8'd0;
            error           <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state           <= ST_RECV;
                        byte_cnt        <= 4'd0;
                        records_written <= 16'd0;
                        done            <= 1'b0;
                        busy            <= 1'b1;
                        in_ready        <= 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum            <= 8'd0;
                        error           <= 1'b0;
`endif
                    end
                end
                ST_RECV: begin
                    if (in_valid && in_ready) begin
                        byte_cnt <= byte_cnt + 4'd1;
                        shreg    <= rec_next;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= 4'd0;
                            in_ready <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                            csum     <= 8'd0;
`endif
                            if (csum_bad) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                                error <= 1'b1;
`endif
                            end else if (rec_next[31:0] == END_ADDR) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state       <= ST_DRIVE;
                                config_addr <= rec_next[31:0];
                                config_data <= rec_next[63:32];
                                hold_cnt    <= '0;
                            end
                        end
                    end
                end
                ST_DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= ST_RECV;
                        in_ready    <= 1'b1;
                        config_addr <= IDLE_ADDR;
                        config_data <= 32'd0;
                        if (records_written != 16'hFFFF)
                            records_written <= records_written + 16'd1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// tb_config_loader: directed stimulus with an expected-write queue checked by
// an independent bus monitor.
// Revision: 1.0
// ============================================================================
module tb_config_loader;

    localparam int          HOLD  = 2;
    localparam logic [31:0] IDLEA = 32'hFFFF_FFFF;
    localparam logic [31:0] ENDA  = 32'hFFFF_FFFE;

    logic        clk, rst, start, in_valid, in_ready, busy, done, error;
    logic [7:0]  in_data;
    logic [31:0] config_addr, config_data;
    logic [15:0] records_written;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    config_loader #(
        .HOLD_CYCLES(HOLD),
        .IDLE_ADDR  (IDLEA),
        .END_ADDR   (ENDA)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .config_addr    (config_addr),
        .config_data    (config_data),
        .busy           (busy),
        .done           (done),
        .records_written(records_written),
        .error          (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a write is a run of non-idle bus cycles; compare it on return to idle.
    initial begin : monitor
        int  run;
        wr_t cur;
        wr_t e;
        run = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else if (config_addr !== IDLEA || config_data !== 32'd0) begin
                if (run == 0) begin
                    cur = {config_addr, config_data};
                end else begin
                    chk("bus_stable_addr", config_addr, cur.a);
                    chk("bus_stable_data", config_data, cur.d);
                end
                chk("in_ready_low_in_drive", 32'(in_ready), 32'd0);
                run++;
            end else if (run > 0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got %h/%h expected none", cur.a, cur.d);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", cur.a, e.a);
                    chk("write_data", cur.d, e.d);
                    chk("write_hold_cycles", 32'(run), 32'(HOLD));
                end
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 200) begin
            n_err++;
            $display("FAIL byte_accept_timeout: got in_ready=0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic send_record(input logic [31:0] a, input logic [31:0] d, input bit toggle);
        logic [63:0] r;
        logic [7:0]  x;
        r = {d, a};
        x = 8'd0;
        if (a != ENDA) exp_q.push_back({a, d});
        for (int i = 0; i < 8; i++) begin
            send_byte(r[8*i +: 8]);
            x = x ^ r[8*i +: 8];
            if (toggle) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_load(input logic [15:0] exp_rw);
        send_record(ENDA, 32'd0, 1'b0);
        in_valid = 1'b0;
        chk("done_set", 32'(done), 32'd1);
        chk("busy_clear", 32'(busy), 32'd0);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("addr_idle_done", config_addr, IDLEA);
        chk("records_written", 32'(records_written), 32'(exp_rw));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stim
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_addr", config_addr, IDLEA);
        chk("rst_data", config_data, 32'd0);
        chk("rst_flags", {27'd0, in_ready, busy, done, error, 1'b0}, 32'd0);
        chk("rst_rw", 32'(records_written), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single record then END.
        do_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        send_record(32'h0005_0002, 32'hDEAD_BEEF, 1'b0);
        finish_load(16'd1);

        // Three back-to-back records, in_valid held high; restart from DONE.
        do_start();
        chk("done_cleared_by_start", 32'(done), 32'd0);
        chk("rw_cleared_by_start", 32'(records_written), 32'd0);
        send_record(32'h0001_0000, 32'h1111_2222, 1'b0);
        send_record(32'h0002_0003, 32'h3333_4444, 1'b0);
        send_record(32'h0007_00FF, 32'h8000_0001, 1'b0);
        finish_load(16'd3);

        // in_valid toggled every other cycle.
        do_start();
        send_record(32'h0005_0002, 32'hDEAD_BEEF, 1'b1);
        send_record(32'h0A0B_0C0D, 32'h0102_0304, 1'b1);
        finish_load(16'd2);

        // start pulsed during DRIVE is ignored.
        do_start();
        send_record(32'h0004_0010, 32'hCAFE_F00D, 1'b0);
        do_start();
        chk("busy_after_ignored_start", 32'(busy), 32'd1);
        send_record(32'h0004_0011, 32'h0BAD_CAFE, 1'b0);
        finish_load(16'd2);

        // Asynchronous reset while a write is on the bus.
        do_start();
        send_record(32'h0003_0001, 32'h5555_AAAA, 1'b0);
        in_valid = 1'b0;
        chk("pre_reset_addr", config_addr, 32'h0003_0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_addr", config_addr, IDLEA);
        chk("async_rst_data", config_data, 32'd0);
        chk("async_rst_flags", {27'd0, in_ready, busy, done, error, 1'b0}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        send_record(32'h0006_0004, 32'h0F0F_F0F0, 1'b0);
        finish_load(16'd1);

`ifdef CONFIG_LOADER_CHECKSUM_EN
        // Corrupted checksum: 0x00 sent where 0x5A belongs.
        do_start();
        for (int i = 0; i < 8; i++) send_byte(i == 0 ? 8'h5A : 8'h00);
        send_byte(8'h00);
        in_valid = 1'b0;
        chk("csum_error", 32'(error), 32'd1);
        chk("csum_done", 32'(done), 32'd0);
        chk("csum_in_ready", 32'(in_ready), 32'd0);
        chk("csum_busy", 32'(busy), 32'd0);
        do_start();
        chk("csum_error_cleared", 32'(error), 32'd0);
        finish_load(16'd0);
`endif

        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
